// File: rtl/ysyx_bus_pkg.sv
// Shared bus types and constants for the read-channel arbiter.
package ysyx_bus_pkg;

  typedef enum logic [1:0] {IDLE, ADDR, DATA} rd_state_t;
  typedef enum logic {OWN_IFU, OWN_LSU} rd_owner_t;

  localparam int ID_W = 4;

  localparam logic [1:0]      AXI_OKAY       = 2'b00;
  localparam logic [1:0]      AXI_BURST_INCR = 2'b01;
  localparam logic [ID_W-1:0] ID_IFU         = 4'd0;
  localparam logic [ID_W-1:0] ID_LSU         = 4'd1;

  // Map an LSU byte-lane mask to an AXI arsize; masks that are not a clean
  // power of two round up to the next size that covers every enabled lane.
  function automatic logic [2:0] strb_to_size(input logic [7:0] strb);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + 4'(strb[i]);
    end
    if (n > 4'd4) begin
      return 3'd3;
    end else if (n > 4'd2) begin
      return 3'd2;
    end else if (n == 4'd2) begin
      return 3'd1;
    end else begin
      return 3'd0;
    end
  endfunction

endpackage

// File: rtl/ysyx_rd_lane_sel.sv
// Picks the 32-bit half of a 64-bit AXI beat for the current beat address
// and produces the address of the following beat of an INCR burst.
module ysyx_rd_lane_sel #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic [63:0]       bus_data,
  input  logic [ADDR_W-1:0] beat_addr,
  output logic [DATA_W-1:0] lane_data,
  output logic [ADDR_W-1:0] next_addr
);

  // Address bit 2 selects the upper or lower word of the 64-bit bus.
  always_comb begin
    lane_data = beat_addr[2] ? DATA_W'(bus_data[63:32]) : DATA_W'(bus_data[31:0]);
    next_addr = beat_addr + ADDR_W'(4);
  end

endmodule

// File: rtl/ysyx_rd_arbiter.sv
// Shares one AXI4 read port between the fetch unit and the load/store unit.
// LSU has priority, IFU is forced after STARVE_MAX back-to-back LSU grants.
// One transaction is outstanding at a time; a flush squashes fetch data.
//
//  state | meaning
//  IDLE  | no transaction; arbitrate between pending requests
//  ADDR  | m_arvalid asserted with latched fields, waiting for m_arready
//  DATA  | m_rready asserted, forwarding beats until m_rlast
module ysyx_rd_arbiter
  import ysyx_bus_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int IFU_BLEN   = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ifu_araddr,
  input  logic              ifu_arvalid,
  output logic              ifu_arready,
  output logic [DATA_W-1:0] ifu_rdata,
  output logic              ifu_rvalid,
  output logic              ifu_rlast,
  input  logic [ADDR_W-1:0] lsu_araddr,
  input  logic [7:0]        lsu_rstrb,
  input  logic              lsu_arvalid,
  output logic              lsu_arready,
  output logic [DATA_W-1:0] lsu_rdata,
  output logic              lsu_rvalid,
  input  logic              flush,
  output logic [ADDR_W-1:0] m_araddr,
  output logic              m_arvalid,
  output logic [ID_W-1:0]   m_arid,
  output logic [7:0]        m_arlen,
  output logic [2:0]        m_arsize,
  output logic [1:0]        m_arburst,
  input  logic              m_arready,
  input  logic [63:0]       m_rdata,
  input  logic [1:0]        m_rresp,
  input  logic              m_rlast,
  input  logic              m_rvalid,
  input  logic [ID_W-1:0]   m_rid,
  output logic              m_rready,
  output logic              rd_err
);

  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_CAP = CNT_W'(STARVE_MAX);

  rd_state_t          state, state_next;
  rd_owner_t          owner_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [ADDR_W-1:0]  beat_addr_q;
  logic [ADDR_W-1:0]  beat_addr_next;
  logic [7:0]         arlen_q;
  logic [2:0]         arsize_q;
  logic [CNT_W-1:0]   starve_cnt;
  logic               squash;
  logic [DATA_W-1:0]  rdata_q;
  logic [DATA_W-1:0]  lane_data;
  logic               starved;
  logic               grant_lsu;
  logic               grant_ifu;
  logic               beat_fire;
  logic               rid_bad;
  logic [ID_W-1:0]    exp_id;

  ysyx_rd_lane_sel #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_lane_sel (
    .bus_data  (m_rdata),
    .beat_addr (beat_addr_q),
    .lane_data (lane_data),
    .next_addr (beat_addr_next)
  );

  // Grant decision in IDLE: LSU first unless IFU has hit the starvation cap;
  // a flush in the same cycle blocks the fetch grant.
  always_comb begin
    starved   = ifu_arvalid && (starve_cnt == STARVE_CAP);
    grant_lsu = (state == IDLE) && lsu_arvalid && !starved;
    grant_ifu = (state == IDLE) && !grant_lsu && ifu_arvalid && !flush;
    exp_id    = (owner_q == OWN_LSU) ? ID_LSU : ID_IFU;
    beat_fire = m_rready && m_rvalid;
    rid_bad   = beat_fire && (m_rid != exp_id);
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (grant_lsu || grant_ifu) state_next = ADDR;
      ADDR: if (m_arready) state_next = DATA;
      DATA: if (m_rvalid && m_rlast) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Bus-side handshake outputs decoded from the state.
  always_comb begin
    m_arvalid = 1'b0;
    m_rready  = 1'b0;
    unique case (state)
      ADDR:    m_arvalid = 1'b1;
      DATA:    m_rready  = 1'b1;
      default: ;
    endcase
  end

  assign m_araddr  = addr_q;
  assign m_arid    = exp_id;
  assign m_arlen   = arlen_q;
  assign m_arsize  = arsize_q;
  assign m_arburst = AXI_BURST_INCR;
  assign ifu_rdata = rdata_q;
  assign lsu_rdata = rdata_q;

  // Request latching, starvation counter, squash and registered beat forwarding.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_q     <= OWN_IFU;
      addr_q      <= '0;
      beat_addr_q <= '0;
      arlen_q     <= '0;
      arsize_q    <= '0;
      starve_cnt  <= '0;
      squash      <= 1'b0;
      rd_err      <= 1'b0;
      rdata_q     <= '0;
      ifu_arready <= 1'b0;
      lsu_arready <= 1'b0;
      ifu_rvalid  <= 1'b0;
      ifu_rlast   <= 1'b0;
      lsu_rvalid  <= 1'b0;
    end else begin
      ifu_arready <= grant_ifu;
      lsu_arready <= grant_lsu;
      ifu_rvalid  <= 1'b0;
      ifu_rlast   <= 1'b0;
      lsu_rvalid  <= 1'b0;

      if (grant_lsu) begin
        owner_q     <= OWN_LSU;
        addr_q      <= lsu_araddr;
        beat_addr_q <= lsu_araddr;
        arlen_q     <= 8'd0;
        arsize_q    <= strb_to_size(lsu_rstrb);
      end else if (grant_ifu) begin
        owner_q     <= OWN_IFU;
        addr_q      <= ifu_araddr;
        beat_addr_q <= ifu_araddr;
        arlen_q     <= 8'(IFU_BLEN - 1);
        arsize_q    <= 3'd2;
      end

      if (!ifu_arvalid || grant_ifu) begin
        starve_cnt <= '0;
      end else if (grant_lsu && (starve_cnt != STARVE_CAP)) begin
        starve_cnt <= starve_cnt + 1'b1;
      end

      // Squash lasts until the drained fetch burst returns the FSM to IDLE.
      if (state_next == IDLE) begin
        squash <= 1'b0;
      end else if (flush && (owner_q == OWN_IFU) && (state != IDLE)) begin
        squash <= 1'b1;
      end

      if (beat_fire) begin
        rdata_q     <= lane_data;
        beat_addr_q <= beat_addr_next;
        if (owner_q == OWN_LSU) begin
          lsu_rvalid <= 1'b1;
        end else if (!squash && !flush) begin
          ifu_rvalid <= 1'b1;
          ifu_rlast  <= m_rlast;
        end
        if ((m_rresp != AXI_OKAY) || rid_bad) begin
          rd_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ysyx_rd_arbiter.sv
// Directed bench for ysyx_rd_arbiter: burst fetch, loads, starvation cap,
// flush squash, sticky error and asynchronous reset.
module tb_ysyx_rd_arbiter;

  logic        clk;
  logic        rst;
  logic [31:0] ifu_araddr;
  logic        ifu_arvalid;
  logic        ifu_arready;
  logic [31:0] ifu_rdata;
  logic        ifu_rvalid;
  logic        ifu_rlast;
  logic [31:0] lsu_araddr;
  logic [7:0]  lsu_rstrb;
  logic        lsu_arvalid;
  logic        lsu_arready;
  logic [31:0] lsu_rdata;
  logic        lsu_rvalid;
  logic        flush;
  logic [31:0] m_araddr;
  logic        m_arvalid;
  logic [3:0]  m_arid;
  logic [7:0]  m_arlen;
  logic [2:0]  m_arsize;
  logic [1:0]  m_arburst;
  logic        m_arready;
  logic [63:0] m_rdata;
  logic [1:0]  m_rresp;
  logic        m_rlast;
  logic        m_rvalid;
  logic [3:0]  m_rid;
  logic        m_rready;
  logic        rd_err;

  int errors = 0;
  int checks = 0;

  ysyx_rd_arbiter #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .IFU_BLEN   (4),
    .STARVE_MAX (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ifu_araddr  (ifu_araddr),
    .ifu_arvalid (ifu_arvalid),
    .ifu_arready (ifu_arready),
    .ifu_rdata   (ifu_rdata),
    .ifu_rvalid  (ifu_rvalid),
    .ifu_rlast   (ifu_rlast),
    .lsu_araddr  (lsu_araddr),
    .lsu_rstrb   (lsu_rstrb),
    .lsu_arvalid (lsu_arvalid),
    .lsu_arready (lsu_arready),
    .lsu_rdata   (lsu_rdata),
    .lsu_rvalid  (lsu_rvalid),
    .flush       (flush),
    .m_araddr    (m_araddr),
    .m_arvalid   (m_arvalid),
    .m_arid      (m_arid),
    .m_arlen     (m_arlen),
    .m_arsize    (m_arsize),
    .m_arburst   (m_arburst),
    .m_arready   (m_arready),
    .m_rdata     (m_rdata),
    .m_rresp     (m_rresp),
    .m_rlast     (m_rlast),
    .m_rvalid    (m_rvalid),
    .m_rid       (m_rid),
    .m_rready    (m_rready),
    .rd_err      (rd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bus slave: wait (bounded) for an address request.
  task automatic wait_ar(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (m_arvalid) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic accept_ar();
    m_arready = 1'b1;
    tick();
    m_arready = 1'b0;
  endtask

  // Drive one read beat; on return the forwarded beat is visible.
  task automatic send_beat(input logic [63:0] d, input logic [1:0] resp,
                           input logic last, input logic [3:0] id);
    m_rvalid = 1'b1;
    m_rdata  = d;
    m_rresp  = resp;
    m_rlast  = last;
    m_rid    = id;
    tick();
    m_rvalid = 1'b0;
    m_rlast  = 1'b0;
    m_rresp  = 2'b00;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    ifu_araddr = '0; ifu_arvalid = 1'b0;
    lsu_araddr = '0; lsu_rstrb = '0; lsu_arvalid = 1'b0;
    flush = 1'b0; m_arready = 1'b0;
    m_rdata = '0; m_rresp = '0; m_rlast = 1'b0; m_rvalid = 1'b0; m_rid = '0;
    repeat (3) tick();
    checks++;
    if ({m_arvalid, m_rready, ifu_arready, lsu_arready} !== 4'b0000)
      $display("FAIL reset_handshake: got %b want 0000", {m_arvalid, m_rready, ifu_arready, lsu_arready});
    checks++;
    if ({ifu_rvalid, lsu_rvalid, rd_err} !== 3'b000)
      $display("FAIL reset_valid_err: got %b want 000", {ifu_rvalid, lsu_rvalid, rd_err});
    checks++;
    if (m_araddr !== 32'h0) begin
      errors++; $display("FAIL reset_araddr: got %h want 00000000", m_araddr);
    end
    errors += ({m_arvalid, m_rready, ifu_arready, lsu_arready} !== 4'b0000) ? 1 : 0;
    errors += ({ifu_rvalid, lsu_rvalid, rd_err} !== 3'b000) ? 1 : 0;
    rst = 1'b1;
    tick();
  endtask

  task automatic test_ifu_burst();
    bit seen;
    logic [63:0] d;
    ifu_araddr = 32'h3000_0000;
    ifu_arvalid = 1'b1;
    tick();
    checks++;
    if (ifu_arready !== 1'b1) begin errors++; $display("FAIL ifu_arready: got %b want 1", ifu_arready); end
    ifu_arvalid = 1'b0;
    wait_ar(seen);
    checks++;
    if (!seen) begin errors++; $display("FAIL ifu_ar_timeout: got no m_arvalid want 1"); return; end
    checks++;
    if ({m_araddr, m_arlen, m_arsize, m_arid, m_arburst} !== {32'h3000_0000, 8'd3, 3'd2, 4'd0, 2'b01}) begin
      errors++;
      $display("FAIL ifu_ar_fields: got addr=%h len=%0d size=%0d id=%0d burst=%0d want 30000000/3/2/0/1",
               m_araddr, m_arlen, m_arsize, m_arid, m_arburst);
    end
    accept_ar();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (m_rready !== 1'b1) begin errors++; $display("FAIL ifu_rready beat%0d: got %b want 1", k, m_rready); end
      d = (k % 2 == 0) ? {32'hDEAD_BEEF, 32'(k)} : {32'(k), 32'hDEAD_BEEF};
      send_beat(d, 2'b00, k == 3, 4'd0);
      checks++;
      if ({ifu_rvalid, ifu_rlast, lsu_rvalid, ifu_rdata} !== {1'b1, (k == 3), 1'b0, 32'(k)}) begin
        errors++;
        $display("FAIL ifu_beat%0d: got v=%b last=%b lv=%b data=%h want 1/%0d/0/%h",
                 k, ifu_rvalid, ifu_rlast, lsu_rvalid, ifu_rdata, k == 3, 32'(k));
      end
    end
    tick();
    checks++;
    if ({ifu_rvalid, m_rready, m_arvalid} !== 3'b000) begin
      errors++; $display("FAIL ifu_after_last: got %b want 000", {ifu_rvalid, m_rready, m_arvalid});
    end
  endtask

  task automatic test_lsu_load();
    logic [7:0] strb_tab[4] = '{8'h02, 8'h03, 8'h0F, 8'hFF};
    logic [2:0] size_tab[4] = '{3'd0, 3'd1, 3'd2, 3'd3};
    logic [31:0] addr_tab[4] = '{32'h8000_0005, 32'h8000_0002, 32'h8000_0008, 32'h8000_0010};
    logic [31:0] want_tab[4] = '{32'hCAFE_0055, 32'h1111_2222, 32'h1111_2222, 32'h1111_2222};
    bit seen;
    for (int t = 0; t < 4; t++) begin
      lsu_araddr = addr_tab[t];
      lsu_rstrb = strb_tab[t];
      lsu_arvalid = 1'b1;
      tick();
      checks++;
      if (lsu_arready !== 1'b1) begin errors++; $display("FAIL lsu_arready t%0d: got %b want 1", t, lsu_arready); end
      lsu_arvalid = 1'b0;
      wait_ar(seen);
      checks++;
      if (!seen) begin errors++; $display("FAIL lsu_ar_timeout t%0d: got none want m_arvalid", t); return; end
      checks++;
      if ({m_araddr, m_arsize, m_arlen, m_arid} !== {addr_tab[t], size_tab[t], 8'd0, 4'd1}) begin
        errors++;
        $display("FAIL lsu_ar_fields t%0d: got addr=%h size=%0d len=%0d id=%0d want %h/%0d/0/1",
                 t, m_araddr, m_arsize, m_arlen, m_arid, addr_tab[t], size_tab[t]);
      end
      accept_ar();
      send_beat({32'hCAFE_0055, 32'h1111_2222}, 2'b00, 1'b1, 4'd1);
      checks++;
      if ({lsu_rvalid, ifu_rvalid, lsu_rdata} !== {1'b1, 1'b0, want_tab[t]}) begin
        errors++;
        $display("FAIL lsu_data t%0d: got v=%b iv=%b data=%h want 1/0/%h", t, lsu_rvalid, ifu_rvalid, lsu_rdata, want_tab[t]);
      end
      tick();
    end
  endtask

  task automatic test_starvation();
    logic [3:0] exp_id[6] = '{4'd1, 4'd1, 4'd1, 4'd0, 4'd1, 4'd1};
    logic [1:0] exp_cnt[6] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd0, 2'd0};
    int lsu_left;
    bit seen;
    logic [3:0] id;
    lsu_left = 5;
    lsu_araddr = 32'h8000_0100; lsu_rstrb = 8'h0F; lsu_arvalid = 1'b1;
    ifu_araddr = 32'h3000_0400; ifu_arvalid = 1'b1;
    for (int t = 0; t < 6; t++) begin
      wait_ar(seen);
      checks++;
      if (!seen) begin errors++; $display("FAIL starve_timeout g%0d: got none want m_arvalid", t); break; end
      id = m_arid;
      checks++;
      if (id !== exp_id[t]) begin errors++; $display("FAIL starve_order g%0d: got id=%0d want %0d", t, id, exp_id[t]); end
      checks++;
      if (dut.starve_cnt !== exp_cnt[t]) begin
        errors++; $display("FAIL starve_cnt g%0d: got %0d want %0d", t, dut.starve_cnt, exp_cnt[t]);
      end
      if (lsu_arready) begin
        lsu_left--;
        lsu_araddr += 32'd8;
        if (lsu_left == 0) lsu_arvalid = 1'b0;
      end
      if (ifu_arready) ifu_arvalid = 1'b0;
      accept_ar();
      if (id == 4'd0) begin
        for (int k = 0; k < 4; k++) send_beat(64'(k), 2'b00, k == 3, 4'd0);
      end else begin
        send_beat(64'h1, 2'b00, 1'b1, 4'd1);
      end
    end
    lsu_arvalid = 1'b0; ifu_arvalid = 1'b0;
    tick();
  endtask

  task automatic test_flush();
    bit seen;
    ifu_araddr = 32'h3000_0040; ifu_arvalid = 1'b1;
    tick();
    ifu_arvalid = 1'b0;
    wait_ar(seen);
    checks++;
    if (!seen) begin errors++; $display("FAIL flush_ar_timeout: got none want m_arvalid"); return; end
    accept_ar();
    for (int k = 0; k < 2; k++) begin
      send_beat({32'h0000_00B1, 32'h0000_00A0}, 2'b00, 1'b0, 4'd0);
      checks++;
      if (ifu_rvalid !== 1'b1) begin errors++; $display("FAIL flush_pre_beat%0d: got %b want 1", k, ifu_rvalid); end
    end
    flush = 1'b1;
    lsu_araddr = 32'h8000_0010; lsu_rstrb = 8'h0F; lsu_arvalid = 1'b1;
    tick();
    flush = 1'b0;
    for (int k = 2; k < 4; k++) begin
      checks++;
      if ({m_rready, lsu_arready} !== 2'b10) begin
        errors++; $display("FAIL flush_drain_ready beat%0d: got rready/lsu_arready=%b want 10", k, {m_rready, lsu_arready});
      end
      send_beat({32'h0000_00B3, 32'h0000_00A2}, 2'b00, k == 3, 4'd0);
      checks++;
      if ({ifu_rvalid, ifu_rlast} !== 2'b00) begin
        errors++; $display("FAIL flush_squash beat%0d: got v/last=%b want 00", k, {ifu_rvalid, ifu_rlast});
      end
    end
    tick();
    checks++;
    if (lsu_arready !== 1'b1) begin errors++; $display("FAIL flush_next_lsu: got %b want 1", lsu_arready); end
    lsu_arvalid = 1'b0;
    wait_ar(seen);
    checks++;
    if (!seen || m_arid !== 4'd1) begin errors++; $display("FAIL flush_lsu_ar: got seen=%b id=%0d want 1/1", seen, m_arid); return; end
    accept_ar();
    send_beat({32'h5A5A_5A5A, 32'h7777_0010}, 2'b00, 1'b1, 4'd1);
    checks++;
    if ({lsu_rvalid, lsu_rdata} !== {1'b1, 32'h7777_0010}) begin
      errors++; $display("FAIL flush_lsu_data: got v=%b data=%h want 1/77770010", lsu_rvalid, lsu_rdata);
    end
    tick();
  endtask

  task automatic test_rresp();
    bit seen;
    checks++;
    if (rd_err !== 1'b0) begin errors++; $display("FAIL err_before: got %b want 0", rd_err); end
    for (int t = 0; t < 2; t++) begin
      lsu_araddr = 32'h8000_0020; lsu_rstrb = 8'hFF; lsu_arvalid = 1'b1;
      tick();
      lsu_arvalid = 1'b0;
      wait_ar(seen);
      checks++;
      if (!seen) begin errors++; $display("FAIL err_ar_timeout t%0d: got none want m_arvalid", t); return; end
      accept_ar();
      send_beat({32'hAAAA_AAAA, 32'h5555_5555}, (t == 0) ? 2'b10 : 2'b00, 1'b1, 4'd1);
      checks++;
      if ({lsu_rvalid, lsu_rdata, rd_err} !== {1'b1, 32'h5555_5555, 1'b1}) begin
        errors++;
        $display("FAIL err_load t%0d: got v=%b data=%h err=%b want 1/55555555/1", t, lsu_rvalid, lsu_rdata, rd_err);
      end
      tick();
    end
  endtask

  task automatic test_async_reset();
    bit seen;
    ifu_araddr = 32'h3000_0100; ifu_arvalid = 1'b1;
    tick();
    ifu_arvalid = 1'b0;
    wait_ar(seen);
    checks++;
    if (!seen) begin errors++; $display("FAIL rst_ar_timeout: got none want m_arvalid"); return; end
    accept_ar();
    send_beat({32'h1, 32'h2}, 2'b00, 1'b0, 4'd0);
    rst = 1'b0;
    #1;
    checks++;
    if ({m_rready, m_arvalid, ifu_rvalid, rd_err, m_araddr} !== {4'b0000, 32'h0}) begin
      errors++;
      $display("FAIL rst_mid_burst: got rready=%b arvalid=%b rvalid=%b err=%b addr=%h want 0/0/0/0/0",
               m_rready, m_arvalid, ifu_rvalid, rd_err, m_araddr);
    end
    ifu_araddr = 32'h3000_0200; ifu_arvalid = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      if (m_arvalid) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen || m_araddr !== 32'h3000_0200) begin
      errors++; $display("FAIL rst_recover: got seen=%b addr=%h want 1/30000200", seen, m_araddr);
    end
    ifu_arvalid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_ifu_burst();
    test_lsu_load();
    test_starvation();
    test_flush();
    test_rresp();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
